// File: rtl/prog_delay_line_pkg.sv
// Shared helpers for programmable delay lines: width calculation and the delay clamp rule.
package prog_delay_line_pkg;

    localparam int unsigned DL_MIN_DELAY = 1;

    // Ceiling log2, at least 1 so zero-width vectors never appear.
    function automatic int unsigned dl_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_depth);
        if (req < DL_MIN_DELAY) begin
            return DL_MIN_DELAY;
        end
        if (req > max_depth) begin
            return max_depth;
        end
        return req;
    endfunction

endpackage

// File: rtl/prog_delay_line_delay_mem.sv
// Sample storage for the delay line: one write port, one asynchronous read port, no reset.
module prog_delay_line_delay_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DBW   = 8,
    parameter int unsigned AW    = 4
) (
    input  logic           i_clock,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [DBW-1:0] i_wdata,
    input  logic [AW-1:0]  i_raddr,
    output logic [DBW-1:0] o_rdata
);

    logic [DBW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Programmable delay line: NCH signed lanes share one write pointer, fill counter and delay.
module prog_delay_line
    import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH         = 168,
    parameter int unsigned NCH           = 1,
    parameter int unsigned MAX_DEPTH     = 16,
    parameter int unsigned DEFAULT_DELAY = 2,
    localparam int unsigned DW           = dl_clog2(MAX_DEPTH + 1)
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic signed [NCH*WIDTH-1:0] i_data,
    input  logic        [DW-1:0]        i_delay,
    input  logic                        i_load,
    input  logic                        i_flush,
    output logic signed [NCH*WIDTH-1:0] o_data,
    output logic                        o_valid
);

    localparam int unsigned AW  = dl_clog2(MAX_DEPTH);
    localparam int unsigned DBW = NCH * WIDTH;

    logic [DW-1:0]  r_d_act;
    logic [DW-1:0]  r_cnt;
    logic [AW-1:0]  r_wptr;
    logic [DBW-1:0] r_data;
    logic           r_valid;

    logic           w_accept;
    logic [DW-1:0]  w_d_new;
    logic [DW-1:0]  w_d_eff;
    logic [DW-1:0]  w_cnt_next;
    logic [AW-1:0]  w_wptr_next;
    logic [AW-1:0]  w_raddr;
    int unsigned    w_rd_idx;
    logic [DBW-1:0] w_rdata;
    logic [DBW-1:0] w_sample;

    always_comb begin
        w_accept    = i_valid & ~i_flush;
        w_d_new     = DW'(clamp_delay(32'(i_delay), MAX_DEPTH));
        w_d_eff     = i_load ? w_d_new : r_d_act;
        w_cnt_next  = (r_cnt == DW'(MAX_DEPTH)) ? r_cnt : r_cnt + DW'(1);
        w_wptr_next = (r_wptr == AW'(MAX_DEPTH - 1)) ? '0 : r_wptr + AW'(1);
        // Entry D-1 slots behind the write pointer; D=1 bypasses storage.
        w_rd_idx    = (32'(r_wptr) + MAX_DEPTH + 1 - 32'(w_d_eff)) % MAX_DEPTH;
        w_raddr     = AW'(w_rd_idx);
        w_sample    = (w_d_eff == DW'(1)) ? i_data : w_rdata;
    end

    prog_delay_line_delay_mem #(
        .DEPTH (MAX_DEPTH),
        .DBW   (DBW),
        .AW    (AW)
    ) u_delay_mem (
        .i_clock (i_clock),
        .i_we    (i_reset & w_accept),
        .i_waddr (r_wptr),
        .i_wdata (i_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_d_act <= DW'(DEFAULT_DELAY);
            r_cnt   <= '0;
            r_wptr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_load) begin
                r_d_act <= w_d_new;
            end
            if (i_flush) begin
                r_cnt   <= '0;
                r_wptr  <= '0;
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (i_valid) begin
                r_cnt   <= w_cnt_next;
                r_wptr  <= w_wptr_next;
                r_data  <= w_sample;
                r_valid <= (w_cnt_next >= w_d_eff);
            end else if (i_load) begin
                // New delay without a sample: current output no longer matches it.
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
